// File: rtl/dmem_trace_buffer_pkg.sv
// Shared types and constants for the data-memory store trace buffer.
package dmem_trace_buffer_pkg;

   // Instruction word that marks the end of the program.
   localparam logic [31:0] HALT_INSTR_WORD = 32'h0800001F;

   // Default entry field widths.
   localparam int TRACE_ADDR_BITS  = 10;
   localparam int TRACE_STAMP_BITS = 16;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      DONE = 2'd2
   } trace_state_e;

   // One captured store at the default address width.
   typedef struct packed {
      logic [TRACE_ADDR_BITS-1:0]  addr;
      logic [31:0]                 data;
      logic [TRACE_STAMP_BITS-1:0] stamp;
   } trace_entry_t;

endpackage

// File: rtl/dmem_trace_buffer_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy output.
// head always shows the oldest entry; while empty it keeps the last
// entry that was shown so downstream outputs do not glitch.
module dmem_trace_buffer_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] last_head;
   logic             do_pop;
   logic             do_push;

   // Extra wrap bit: equal indices with differing wrap bits means full.
   assign level   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when a pop frees the head slot.
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? last_head : mem[rd_ptr[AW-1:0]];

   // Pointer update and capture of the most recently shown head.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         last_head <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (!empty)  last_head <= mem[rd_ptr[AW-1:0]];
      end
   end

   // Storage array; contents are only read when the FIFO is non-empty.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/dmem_trace_buffer.sv
// Captures soc data-memory stores into a FIFO with a cycle stamp,
// stops capturing at the halt instruction, and reports run statistics.
module dmem_trace_buffer
   import dmem_trace_buffer_pkg::*;
#(
   parameter int          DEPTH      = 16,
   parameter int          ADDR_BITS  = TRACE_ADDR_BITS,
   parameter logic [31:0] HALT_INSTR = HALT_INSTR_WORD
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       dmem_we,
   input  logic [31:0]                alu_out,
   input  logic [31:0]                dmem_wd,
   input  logic [31:0]                instruction,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic [ADDR_BITS-1:0]       trace_addr,
   output logic [31:0]                trace_data,
   output logic [15:0]                trace_stamp,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic                       halted,
   output logic                       done,
   output logic [15:0]                instr_count
);

   typedef struct packed {
      logic [ADDR_BITS-1:0] addr;
      logic [31:0]          data;
      logic [15:0]          stamp;
   } entry_t;

   trace_state_e state;
   trace_state_e state_next;
   entry_t       wr_entry;
   entry_t       head;
   logic         halt_seen;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;
   logic         unused_addr_bits;

   // Only the low address bits are traced.
   assign unused_addr_bits = ^alu_out[31:ADDR_BITS];

   assign halt_seen   = (instruction == HALT_INSTR);
   // The halt-detect cycle is still RUN, so a store there is captured.
   assign push        = dmem_we && (state == RUN);
   assign pop         = trace_valid && trace_ready;
   assign wr_entry    = '{addr: alu_out[ADDR_BITS-1:0], data: dmem_wd, stamp: instr_count};
   assign trace_valid = !empty;
   assign trace_addr  = head.addr;
   assign trace_data  = head.data;
   assign trace_stamp = head.stamp;
   assign halted      = (state != RUN);
   assign done        = (state == DONE);

   dmem_trace_buffer_sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (wr_entry),
      .pop       (trace_ready),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   // Run state register.
   always_ff @(posedge clock) begin
      if (reset) state <= RUN;
      else       state <= state_next;
   end

   // Run -> halt on the end instruction, halt -> done once drained.
   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (halt_seen) state_next = HALT;
         HALT:    if (level == '0) state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = RUN;
      endcase
   end

   // Saturating instruction counter; frozen from the halt cycle on.
   always_ff @(posedge clock) begin
      if (reset)
         instr_count <= '0;
      else if ((state == RUN) && !halt_seen && (instr_count != 16'hFFFF))
         instr_count <= instr_count + 16'd1;
   end

   // Sticky flag for a store lost to a full FIFO with no pop to make room.
   always_ff @(posedge clock) begin
      if (reset)
         overflow <= 1'b0;
      else if (push && full && !pop)
         overflow <= 1'b1;
   end

endmodule

// File: tb/tb_dmem_trace_buffer.sv
// Randomised scoreboard bench for dmem_trace_buffer.
module tb_dmem_trace_buffer;
   import dmem_trace_buffer_pkg::*;

   localparam int DEPTH = 16;
   localparam int AB    = 10;

   logic        clock = 1'b0;
   logic        reset;
   logic        dmem_we;
   logic [31:0] alu_out;
   logic [31:0] dmem_wd;
   logic [31:0] instruction;
   logic        trace_valid;
   logic        trace_ready;
   logic [AB-1:0] trace_addr;
   logic [31:0] trace_data;
   logic [15:0] trace_stamp;
   logic [$clog2(DEPTH):0] level;
   logic        overflow;
   logic        halted;
   logic        done;
   logic [15:0] instr_count;

   dmem_trace_buffer #(.DEPTH(DEPTH), .ADDR_BITS(AB), .HALT_INSTR(HALT_INSTR_WORD)) dut (
      .clock       (clock),
      .reset       (reset),
      .dmem_we     (dmem_we),
      .alu_out     (alu_out),
      .dmem_wd     (dmem_wd),
      .instruction (instruction),
      .trace_valid (trace_valid),
      .trace_ready (trace_ready),
      .trace_addr  (trace_addr),
      .trace_data  (trace_data),
      .trace_stamp (trace_stamp),
      .level       (level),
      .overflow    (overflow),
      .halted      (halted),
      .done        (done),
      .instr_count (instr_count)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   bit armed = 1'b0;

   // Reference model state (value as seen before the next rising edge).
   trace_entry_t sb[$];
   trace_entry_t shown = '0;
   int  m_lvl = 0;
   bit  m_ovf = 1'b0;
   int  m_st  = 0;   // 0 running, 1 halted, 2 done
   int  m_cnt = 0;
   int  m_pre;
   bit  m_pop, m_push;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: check status outputs, then apply what the coming edge does.
   always @(negedge clock) begin
      if (armed) begin
         chk("level", 64'(level), 64'(m_lvl));
         chk("trace_valid", 64'(trace_valid), 64'(m_lvl > 0));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         chk("halted", 64'(halted), 64'(m_st != 0));
         chk("done", 64'(done), 64'(m_st == 2));
         chk("instr_count", 64'(instr_count), 64'(m_cnt));
      end
      if (reset) begin
         sb.delete();
         m_lvl = 0; m_ovf = 0; m_st = 0; m_cnt = 0;
      end else begin
         m_pre  = m_lvl;
         m_pop  = trace_ready && (m_lvl > 0);
         m_push = dmem_we && (m_st == 0);
         if (m_push) begin
            if (m_lvl < DEPTH || m_pop) begin
               sb.push_back('{addr: alu_out[AB-1:0], data: dmem_wd, stamp: 16'(m_cnt)});
               m_lvl++;
            end else m_ovf = 1'b1;
         end
         if (m_pop) m_lvl--;
         if (m_st == 0) begin
            if (instruction == HALT_INSTR_WORD) m_st = 1;
            else if (m_cnt < 65535) m_cnt++;
         end else if (m_st == 1 && m_pre == 0) m_st = 2;
      end
   end

   // Monitor: compare presented head against the scoreboard, pop on handshake.
   always @(negedge clock) begin
      if (armed && !reset) begin
         if (trace_valid) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL head actual=%0h required=none (queue empty) t=%0t",
                        {trace_addr, trace_data, trace_stamp}, $time);
            end else begin
               chk("head", 64'({trace_addr, trace_data, trace_stamp}), 64'(sb[0]));
               shown = sb[0];
               if (trace_ready) void'(sb.pop_front());
            end
         end else begin
            chk("held", 64'({trace_addr, trace_data, trace_stamp}), 64'(shown));
         end
      end
      if (reset) shown = '0;
   end

   function automatic logic [31:0] rnd_instr();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT_INSTR_WORD) w = 32'h0;
      return w;
   endfunction

   task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] d,
                      input bit rdy, input bit halt);
      dmem_we = we; alu_out = a; dmem_wd = d; trace_ready = rdy;
      instruction = halt ? HALT_INSTR_WORD : rnd_instr();
      @(posedge clock); #1;
   endtask

   task automatic do_reset(input bit rdy);
      reset = 1'b1; dmem_we = $urandom; trace_ready = rdy; instruction = rnd_instr();
      @(posedge clock); #1;
      armed = 1'b1;
      reset = 1'b0;
   endtask

   task automatic drain(input int n);
      repeat (n) cyc(1'b0, $urandom, $urandom, 1'b1, 1'b0);
   endtask

   task automatic stores(input int n, input bit rdy);
      repeat (n) cyc(1'b1, $urandom, $urandom, rdy, 1'b0);
   endtask

   logic [31:0] t1_addr [8] = '{32'h1FC, 32'h1F8, 32'h1F4, 32'h1F0, 32'h1EC, 32'h1E8, 32'h1E4, 32'h1E0};
   logic [31:0] t1_data [8] = '{32'h4, 32'hC, 32'h3, 32'h58, 32'h2, 32'h58, 32'h1, 32'h58};

   initial begin
      reset = 1'b1; dmem_we = 1'b0; alu_out = '0; dmem_wd = '0;
      instruction = 32'h0; trace_ready = 1'b0;

      // Fixed store sequence, held then drained in order.
      do_reset(1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b1, t1_addr[i], t1_data[i], 1'b0, 1'b0);
      cyc(1'b0, 0, 0, 1'b0, 1'b0);
      drain(10);

      // Full FIFO: 17th store dropped.
      do_reset(1'b0);
      stores(DEPTH, 1'b0);
      cyc(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      drain(DEPTH + 2);

      // Full FIFO: 17th store with a pop in the same cycle.
      do_reset(1'b0);
      stores(DEPTH, 1'b0);
      cyc(1'b1, $urandom, $urandom, 1'b1, 1'b0);
      drain(DEPTH + 2);

      // Streaming with ready held high.
      do_reset(1'b1);
      stores(12, 1'b1);
      drain(3);

      // Halt with entries queued; later stores ignored; drain to done.
      do_reset(1'b0);
      stores(3, 1'b0);
      cyc(1'b0, 0, 0, 1'b0, 1'b1);
      stores(3, 1'b0);
      drain(6);
      stores(2, 1'b1);

      // Store in the halt cycle is captured, later ones are not.
      do_reset(1'b0);
      stores(2, 1'b0);
      cyc(1'b1, $urandom, $urandom, 1'b0, 1'b1);
      stores(2, 1'b0);
      drain(6);

      // Reset mid-drain.
      do_reset(1'b0);
      stores(5, 1'b0);
      drain(2);
      do_reset(1'b1);
      cyc(1'b0, 0, 0, 1'b0, 1'b0);
      stores(2, 1'b0);
      drain(3);

      // Random traffic with varying consumer pressure.
      do_reset(1'b0);
      for (int i = 0; i < 600; i++) begin
         int rp;
         rp = (i / 100) % 3;
         if ($urandom_range(199) == 0) do_reset($urandom);
         else cyc($urandom_range(1), $urandom, $urandom,
                  (rp == 0) ? ($urandom_range(3) == 0) : (rp == 1) ? $urandom_range(1) : 1'b1,
                  $urandom_range(149) == 0);
      end
      drain(DEPTH + 4);
      cyc(1'b0, 0, 0, 1'b0, 1'b0);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
